// File: rtl/fdiv.sv
`default_nettype none
// ============================================================================
// Module   : fdiv
// Purpose  : Iterative binary32 divider, rslt = x / y. Radix-2 restoring,
//            one quotient bit per clock, round-to-nearest-even, full
//            subnormal support. Fixed 28-clock latency from acceptance.
// Revision : 1.0  initial release
// ============================================================================
module fdiv #(
    parameter logic [31:0] QNAN = 32'hffc00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        valid,
    output logic [31:0] rslt,
    output logic [4:0]  flag
);

    typedef enum logic [1:0] {S_IDLE, S_PREP, S_DIV, S_RND} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_x, r_y;
    logic [4:0]  r_cnt;
    logic [24:0] r_rem;
    logic [23:0] r_my;
    logic [25:0] r_q;
    logic [9:0]  r_exp;
    logic        r_sign;
    logic        r_special;
    logic [31:0] r_sp_rslt;
    logic [4:0]  r_sp_flag;
    logic        r_valid;
    logic [31:0] r_rslt;
    logic [4:0]  r_flag;

    // Leading-zero count of a 24-bit significand (24 when all zero).
    function automatic logic [4:0] f_lzc24(input logic [23:0] v);
        logic [4:0] n;
        n = 5'd24;
        for (int i = 0; i < 24; i++) begin
            if (v[i]) n = 5'(23 - i);
        end
        return n;
    endfunction

    // ---------------- operand decode (used in PREP) ----------------
    logic [7:0]  w_xe, w_ye;
    logic [22:0] w_xf, w_yf;
    logic        w_x_nan, w_y_nan, w_x_snan, w_y_snan;
    logic        w_x_inf, w_y_inf, w_x_zero, w_y_zero, w_sign;
    logic [23:0] w_mx0, w_my0, w_mxn, w_myn;
    logic [4:0]  w_lzx, w_lzy;
    logic [9:0]  w_ex, w_ey, w_e;
    logic        w_mx_lt;
    logic [24:0] w_mxs;

    assign w_xe     = r_x[30:23];
    assign w_ye     = r_y[30:23];
    assign w_xf     = r_x[22:0];
    assign w_yf     = r_y[22:0];
    assign w_x_nan  = (&w_xe) & (|w_xf);
    assign w_y_nan  = (&w_ye) & (|w_yf);
    assign w_x_snan = w_x_nan & ~w_xf[22];
    assign w_y_snan = w_y_nan & ~w_yf[22];
    assign w_x_inf  = (&w_xe) & ~(|w_xf);
    assign w_y_inf  = (&w_ye) & ~(|w_yf);
    assign w_x_zero = ~(|r_x[30:0]);
    assign w_y_zero = ~(|r_y[30:0]);
    assign w_sign   = r_x[31] ^ r_y[31];

    // Subnormals: exponent field 0 behaves as 1, then left-normalise.
    assign w_mx0   = {|w_xe, w_xf};
    assign w_my0   = {|w_ye, w_yf};
    assign w_lzx   = f_lzc24(w_mx0);
    assign w_lzy   = f_lzc24(w_my0);
    assign w_mxn   = w_mx0 << w_lzx;
    assign w_myn   = w_my0 << w_lzy;
    assign w_ex    = {2'b00, ((w_xe == 8'd0) ? 8'd1 : w_xe)} - {5'b0, w_lzx};
    assign w_ey    = {2'b00, ((w_ye == 8'd0) ? 8'd1 : w_ye)} - {5'b0, w_lzy};
    // Pre-scaling the dividend guarantees the quotient integer bit is 1.
    assign w_mx_lt = (w_mxn < w_myn);
    assign w_mxs   = w_mx_lt ? {w_mxn, 1'b0} : {1'b0, w_mxn};
    assign w_e     = w_ex - w_ey + 10'd127 - {9'b0, w_mx_lt};

    logic        w_sp;
    logic [31:0] w_sp_rslt;
    logic [4:0]  w_sp_flag;

    // Special-operand results in priority order.
    always_comb begin
        w_sp      = 1'b1;
        w_sp_rslt = 32'h0;
        w_sp_flag = 5'h0;
        if (w_x_nan) begin
            w_sp_rslt = r_x | 32'h00400000;
            w_sp_flag = {w_x_snan | w_y_snan, 4'b0};
        end else if (w_y_nan) begin
            w_sp_rslt = r_y | 32'h00400000;
            w_sp_flag = {w_x_snan | w_y_snan, 4'b0};
        end else if ((w_x_zero & w_y_zero) | (w_x_inf & w_y_inf)) begin
            w_sp_rslt = QNAN;
            w_sp_flag = 5'b10000;
        end else if (w_x_inf) begin
            w_sp_rslt = {w_sign, 8'hff, 23'h0};
        end else if (w_y_zero) begin
            w_sp_rslt = {w_sign, 8'hff, 23'h0};
            w_sp_flag = 5'b01000;
        end else if (w_x_zero | w_y_inf) begin
            w_sp_rslt = {w_sign, 31'h0};
        end else begin
            w_sp = 1'b0;
        end
    end

    // ---------------- restoring divide step ----------------
    logic        w_ge;
    logic [24:0] w_rem_sub;

    assign w_ge      = (r_rem >= {1'b0, r_my});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_my}) : r_rem;

    // ---------------- round and pack (used in RND) ----------------
    logic        w_tiny, w_lost, w_g, w_r, w_up, w_nx, w_ovf;
    logic [9:0]  w_shraw, w_en;
    logic [4:0]  w_sh;
    logic [51:0] w_wide;
    logic [25:0] w_qs;
    logic [24:0] w_mr;
    logic [31:0] w_res;
    logic [4:0]  w_flg;

    assign w_tiny  = r_exp[9] | (r_exp == 10'd0);
    assign w_shraw = 10'd1 - r_exp;
    assign w_sh    = w_tiny ? ((w_shraw > 10'd26) ? 5'd26 : w_shraw[4:0]) : 5'd0;
    assign w_wide  = {r_q, 26'b0} >> w_sh;
    assign w_qs    = w_wide[51:26];
    assign w_lost  = |w_wide[25:0];
    assign w_g     = w_qs[1];
    assign w_r     = w_qs[0] | w_lost | (|r_rem);
    assign w_up    = w_g & (w_r | w_qs[2]);
    assign w_mr    = {1'b0, w_qs[25:2]} + {24'b0, w_up};
    assign w_nx    = w_g | w_r;
    assign w_en    = r_exp + {9'b0, w_mr[24]};
    assign w_ovf   = ~w_tiny & (w_en >= 10'd255);

    // Select the final packed result and exception flags.
    always_comb begin
        w_res = {r_sign, 31'h0};
        w_flg = 5'h0;
        if (r_special) begin
            w_res = r_sp_rslt;
            w_flg = r_sp_flag;
        end else if (w_ovf) begin
            w_res = {r_sign, 8'hff, 23'h0};
            w_flg = 5'b00101;
        end else if (w_tiny) begin
            w_res = {r_sign, 7'b0, w_mr[23], w_mr[22:0]};
            w_flg = {3'b000, w_nx, w_nx};
        end else begin
            w_res = {r_sign, w_en[7:0], w_mr[22:0]};
            w_flg = {4'b0000, w_nx};
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state sequencing: accept, prepare, 26 divide steps, round.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (req) w_next = S_PREP;
            S_PREP: w_next = S_DIV;
            S_DIV:  if (r_cnt == 5'd25) w_next = S_RND;
            S_RND:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath registers per state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x       <= 32'h0;
            r_y       <= 32'h0;
            r_cnt     <= 5'd0;
            r_rem     <= 25'h0;
            r_my      <= 24'h0;
            r_q       <= 26'h0;
            r_exp     <= 10'h0;
            r_sign    <= 1'b0;
            r_special <= 1'b0;
            r_sp_rslt <= 32'h0;
            r_sp_flag <= 5'h0;
            r_valid   <= 1'b0;
            r_rslt    <= 32'h0;
            r_flag    <= 5'h0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_x <= x;
                        r_y <= y;
                    end
                end
                S_PREP: begin
                    r_rem     <= w_mxs;
                    r_my      <= w_myn;
                    r_exp     <= w_e;
                    r_sign    <= w_sign;
                    r_special <= w_sp;
                    r_sp_rslt <= w_sp_rslt;
                    r_sp_flag <= w_sp_flag;
                    r_q       <= 26'h0;
                    r_cnt     <= 5'd0;
                end
                S_DIV: begin
                    r_rem <= {w_rem_sub[23:0], 1'b0};
                    r_q   <= {r_q[24:0], w_ge};
                    r_cnt <= r_cnt + 5'd1;
                end
                S_RND: begin
                    r_valid <= 1'b1;
                    r_rslt  <= w_res;
                    r_flag  <= w_flg;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (r_state != S_IDLE);
    assign valid = r_valid;
    assign rslt  = r_rslt;
    assign flag  = r_flag;

endmodule
`default_nettype wire
